// File: rtl/ddr3_tg_pkg.sv
// Shared types and constants for the DDR3 AXI traffic generator.
// The data pattern is selected at build time with the DDR3_TG_LFSR_EN macro
// (defined: Galois LFSR stream; undefined: beat address xor seed).
package ddr3_tg_pkg;

   typedef enum logic [2:0] {
      TG_IDLE,
      TG_WR_AW,
      TG_WR_W,
      TG_WR_B,
      TG_RD_AR,
      TG_RD_R,
      TG_DONE
   } tg_state_e;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;

   // One step of a right-shifting Galois LFSR: taps are applied when the bit shifted out is 1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
   endfunction

endpackage

// File: rtl/ddr3_tg_pattern.sv
// Data pattern generator shared by the write and read phases.
// With DDR3_TG_LFSR_EN defined the data is an LFSR stream reloaded with SEED on load and advanced
// on step; otherwise the data is the beat address xor SEED and load/step have no effect.
module ddr3_tg_pattern
   import ddr3_tg_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] addr,
   output logic [31:0] data
);

`ifdef DDR3_TG_LFSR_EN
   logic [31:0] lfsr_q;
   logic        unused_addr;

   assign unused_addr = ^addr;

   // LFSR register: reload on load, advance once per accepted beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= SEED;
      end else if (load) begin
         lfsr_q <= SEED;
      end else if (step) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign data = lfsr_q;
`else
   logic unused_ctrl;

   assign unused_ctrl = ^{clk_i, rst_ni, load, step};
   assign data        = addr ^ SEED;
`endif

endmodule

// File: rtl/ddr3_axi_traffic_gen.sv
// AXI4 initiator memory self-test: writes NUM_BURSTS INCR bursts of a known pattern from BASE_ADDR,
// reads them back and counts mismatches and bad responses. One transaction outstanding at a time.
// Pattern source is chosen by the DDR3_TG_LFSR_EN macro inside ddr3_tg_pattern.
module ddr3_axi_traffic_gen
   import ddr3_tg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned NUM_BURSTS = 16,
   parameter logic [3:0]  AXI_ID     = 4'h3,
   parameter logic [31:0] SEED       = 32'hA5A5_5A5A
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_count_o,
   output logic        outport_awvalid_o,
   output logic [31:0] outport_awaddr_o,
   output logic [3:0]  outport_awid_o,
   output logic [7:0]  outport_awlen_o,
   output logic [1:0]  outport_awburst_o,
   input  logic        outport_awready_i,
   output logic        outport_wvalid_o,
   output logic [31:0] outport_wdata_o,
   output logic [3:0]  outport_wstrb_o,
   output logic        outport_wlast_o,
   input  logic        outport_wready_i,
   input  logic        outport_bvalid_i,
   input  logic [1:0]  outport_bresp_i,
   input  logic [3:0]  outport_bid_i,
   output logic        outport_bready_o,
   output logic        outport_arvalid_o,
   output logic [31:0] outport_araddr_o,
   output logic [3:0]  outport_arid_o,
   output logic [7:0]  outport_arlen_o,
   output logic [1:0]  outport_arburst_o,
   input  logic        outport_arready_i,
   input  logic        outport_rvalid_i,
   input  logic [31:0] outport_rdata_i,
   input  logic [1:0]  outport_rresp_i,
   input  logic [3:0]  outport_rid_i,
   input  logic        outport_rlast_i,
   output logic        outport_rready_o
);

   localparam logic [7:0]  LAST_BEAT    = 8'(BURST_LEN - 1);
   localparam logic [15:0] LAST_BURST   = 16'(NUM_BURSTS - 1);
   localparam logic [31:0] BURST_STRIDE = 32'(BURST_LEN * 4);

   tg_state_e   state_q, state_d;
   logic [15:0] burst_q;
   logic [31:0] burst_addr_q;
   logic [7:0]  beat_q;
   logic [15:0] err_q;
   logic        done_q;

   logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
   logic        start_acc;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic        last_beat, last_burst;
   logic [31:0] beat_addr;
   logic [31:0] pat_data;
   logic        pat_load, pat_step;
   logic [2:0]  err_inc;
   logic [16:0] err_sum;
   logic [15:0] err_next;

   assign last_beat  = (beat_q == LAST_BEAT);
   assign last_burst = (burst_q == LAST_BURST);
   assign beat_addr  = burst_addr_q + {22'b0, beat_q, 2'b00};

   assign aw_hs = aw_valid && outport_awready_i;
   assign w_hs  = w_valid && outport_wready_i;
   assign b_hs  = b_ready && outport_bvalid_i;
   assign ar_hs = ar_valid && outport_arready_i;
   assign r_hs  = r_ready && outport_rvalid_i;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_ni) begin
         state_q <= TG_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and per-state channel strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      aw_valid  = 1'b0;
      w_valid   = 1'b0;
      b_ready   = 1'b0;
      ar_valid  = 1'b0;
      r_ready   = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         TG_IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               state_d   = TG_WR_AW;
            end
         end
         TG_WR_AW: begin
            aw_valid = 1'b1;
            if (outport_awready_i) state_d = TG_WR_W;
         end
         TG_WR_W: begin
            w_valid = 1'b1;
            if (outport_wready_i && last_beat) state_d = TG_WR_B;
         end
         TG_WR_B: begin
            b_ready = 1'b1;
            if (outport_bvalid_i) state_d = last_burst ? TG_RD_AR : TG_WR_AW;
         end
         TG_RD_AR: begin
            ar_valid = 1'b1;
            if (outport_arready_i) state_d = TG_RD_R;
         end
         TG_RD_R: begin
            r_ready = 1'b1;
            if (outport_rvalid_i && last_beat) state_d = last_burst ? TG_DONE : TG_RD_AR;
         end
         TG_DONE: begin
            state_d = TG_IDLE;
         end
         default: begin
            state_d = TG_IDLE;
         end
      endcase
   end

   // Error increment for this cycle: each faulty field of a B or R handshake counts once.
   always_comb begin
      err_inc = 3'd0;
      if (b_hs) begin
         err_inc = {2'b00, outport_bresp_i != AXI_RESP_OKAY}
                 + {2'b00, outport_bid_i != AXI_ID};
      end else if (r_hs) begin
         err_inc = {2'b00, outport_rresp_i != AXI_RESP_OKAY}
                 + {2'b00, outport_rid_i != AXI_ID}
                 + {2'b00, outport_rdata_i != pat_data}
                 + {2'b00, outport_rlast_i != last_beat};
      end
   end

   assign err_sum  = {1'b0, err_q} + {14'b0, err_inc};
   assign err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];

   // Burst/beat position, address, error count and done flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         burst_q      <= '0;
         burst_addr_q <= '0;
         beat_q       <= '0;
         err_q        <= '0;
         done_q       <= 1'b0;
      end else if (start_acc) begin
         burst_q      <= '0;
         burst_addr_q <= BASE_ADDR;
         beat_q       <= '0;
         err_q        <= '0;
         done_q       <= 1'b0;
      end else begin
         if (w_hs || r_hs) begin
            beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
         end
         if (b_hs) begin
            // After the final write response the read phase restarts from the first burst.
            burst_q      <= last_burst ? 16'd0 : burst_q + 16'd1;
            burst_addr_q <= last_burst ? BASE_ADDR : burst_addr_q + BURST_STRIDE;
         end else if (r_hs && last_beat) begin
            burst_q      <= burst_q + 16'd1;
            burst_addr_q <= burst_addr_q + BURST_STRIDE;
         end
         err_q <= err_next;
         if (state_q == TG_DONE) done_q <= 1'b1;
      end
   end

   // Re-seeding at the write/read boundary makes expected read data match written data beat-for-beat.
   assign pat_load = start_acc || (b_hs && last_burst);
   assign pat_step = w_hs || r_hs;

   ddr3_tg_pattern #(
      .SEED (SEED)
   ) u_pattern (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load   (pat_load),
      .step   (pat_step),
      .addr   (beat_addr),
      .data   (pat_data)
   );

   // Payloads are forced to zero whenever their valid is low.
   assign outport_awvalid_o = aw_valid;
   assign outport_awaddr_o  = aw_valid ? burst_addr_q : 32'd0;
   assign outport_awid_o    = aw_valid ? AXI_ID : 4'd0;
   assign outport_awlen_o   = aw_valid ? LAST_BEAT : 8'd0;
   assign outport_awburst_o = aw_valid ? AXI_BURST_INCR : 2'd0;

   assign outport_wvalid_o  = w_valid;
   assign outport_wdata_o   = w_valid ? pat_data : 32'd0;
   assign outport_wstrb_o   = w_valid ? 4'hF : 4'h0;
   assign outport_wlast_o   = w_valid && last_beat;

   assign outport_bready_o  = b_ready;

   assign outport_arvalid_o = ar_valid;
   assign outport_araddr_o  = ar_valid ? burst_addr_q : 32'd0;
   assign outport_arid_o    = ar_valid ? AXI_ID : 4'd0;
   assign outport_arlen_o   = ar_valid ? LAST_BEAT : 8'd0;
   assign outport_arburst_o = ar_valid ? AXI_BURST_INCR : 2'd0;

   assign outport_rready_o  = r_ready;

   assign busy_o      = (state_q != TG_IDLE);
   assign done_o      = done_q;
   assign pass_o      = done_q && (err_q == 16'd0);
   assign err_count_o = err_q;

endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// Scoreboard bench for ddr3_axi_traffic_gen: a behavioural AXI slave with fault injection, expected
// AW/W/AR/result queues filled when a pass is started, and a monitor that checks each handshake
// and each completed pass against those queues.
`timescale 1ns/1ps
module tb_ddr3_axi_traffic_gen;

   localparam int unsigned BL   = 4;
   localparam int unsigned NB   = 2;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [3:0]  ID   = 4'h3;
   localparam logic [31:0] SEED = 32'hA5A5_5A5A;

   // Hand-computed vectors for BASE=0, BURST_LEN=4, NUM_BURSTS=2: burst addresses and addr^SEED data.
   localparam logic [31:0] AW_ADDR [NB] = '{32'h0000_0000, 32'h0000_0010};
   localparam logic [31:0] W_DATA [NB*BL] = '{
      32'hA5A5_5A5A, 32'hA5A5_5A5E, 32'hA5A5_5A52, 32'hA5A5_5A56,
      32'hA5A5_5A4A, 32'hA5A5_5A4E, 32'hA5A5_5A42, 32'hA5A5_5A46};

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy, done, pass;
   logic [15:0] err_count;
   logic awvalid, awready; logic [31:0] awaddr; logic [3:0] awid; logic [7:0] awlen; logic [1:0] awburst;
   logic wvalid, wready, wlast; logic [31:0] wdata; logic [3:0] wstrb;
   logic bvalid, bready; logic [1:0] bresp; logic [3:0] bid;
   logic arvalid, arready; logic [31:0] araddr; logic [3:0] arid; logic [7:0] arlen; logic [1:0] arburst;
   logic rvalid, rready, rlast; logic [31:0] rdata; logic [1:0] rresp; logic [3:0] rid;

   always #5 clk = ~clk;

   ddr3_axi_traffic_gen #(
      .BASE_ADDR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB), .AXI_ID(ID), .SEED(SEED)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
      .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awid_o(awid),
      .outport_awlen_o(awlen), .outport_awburst_o(awburst), .outport_awready_i(awready),
      .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
      .outport_wlast_o(wlast), .outport_wready_i(wready),
      .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bid_i(bid), .outport_bready_o(bready),
      .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arid_o(arid),
      .outport_arlen_o(arlen), .outport_arburst_o(arburst), .outport_arready_i(arready),
      .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
      .outport_rid_i(rid), .outport_rlast_i(rlast), .outport_rready_o(rready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_data(input int n, input int k);
      logic [31:0] v;
`ifdef DDR3_TG_LFSR_EN
      v = SEED;
      for (int i = 0; i < n * int'(BL) + k; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
`else
      v = W_DATA[n * int'(BL) + k];
`endif
      return v;
   endfunction

   // ---------------- scoreboard queues ----------------
   logic [31:0] aw_exp [$];
   logic [32:0] w_exp [$];
   logic [31:0] ar_exp [$];
   logic [15:0] res_exp [$];

   task automatic expect_pass(input logic [15:0] err);
      for (int n = 0; n < int'(NB); n++) begin
         aw_exp.push_back(AW_ADDR[n]);
         for (int k = 0; k < int'(BL); k++) w_exp.push_back({k == int'(BL) - 1, exp_data(n, k)});
         ar_exp.push_back(AW_ADDR[n]);
      end
      res_exp.push_back(err);
   endtask

   task automatic flush_exp();
      aw_exp.delete(); w_exp.delete(); ar_exp.delete(); res_exp.delete();
   endtask

   // ---------------- behavioural AXI slave ----------------
   int unsigned ready_pct = 100;
   int inj_bresp_burst = -1;
   int inj_rdata_burst = -1, inj_rdata_beat = -1;
   int inj_rid_burst = -1, inj_rid_beat = -1;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] s_aw_q [$];
   logic [31:0] s_ar_q [$];
   logic [1:0]  s_b_q [$];
   logic [31:0] s_waddr;
   int s_wbeat = 0, s_rbeat = 0;
   bit f_aw, f_w, f_b, f_ar, f_r;
   logic [31:0] c_awaddr, c_wdata, c_araddr;
   logic c_wlast;

   initial begin : slave
      int idx;
      logic [31:0] a;
      awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0; bid = 0;
      rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            s_aw_q.delete(); s_ar_q.delete(); s_b_q.delete();
            s_wbeat = 0; s_rbeat = 0;
            f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
            continue;
         end
         if (f_aw) s_aw_q.push_back(c_awaddr);
         if (f_w) begin
            if (s_wbeat == 0 && s_aw_q.size() > 0) s_waddr = s_aw_q.pop_front();
            mem[s_waddr + 32'(s_wbeat * 4)] = c_wdata;
            if (c_wlast) begin
               idx = int'((s_waddr - BASE) / (BL * 4));
               s_b_q.push_back(idx == inj_bresp_burst ? 2'b10 : 2'b00);
               s_wbeat = 0;
            end else begin
               s_wbeat++;
            end
         end
         if (f_b) begin
            bvalid = 0;
            void'(s_b_q.pop_front());
         end
         if (!bvalid && s_b_q.size() > 0) begin
            bvalid = 1; bresp = s_b_q[0]; bid = ID;
         end
         if (f_ar) s_ar_q.push_back(c_araddr);
         if (f_r) begin
            s_rbeat++;
            if (s_rbeat == int'(BL)) begin
               s_rbeat = 0;
               void'(s_ar_q.pop_front());
            end
         end
         if (s_ar_q.size() > 0) begin
            idx   = int'((s_ar_q[0] - BASE) / (BL * 4));
            a     = s_ar_q[0] + 32'(s_rbeat * 4);
            rvalid = 1;
            rdata = mem.exists(a) ? mem[a] : 32'd0;
            if (idx == inj_rdata_burst && s_rbeat == inj_rdata_beat) rdata[0] = ~rdata[0];
            rid   = (idx == inj_rid_burst && s_rbeat == inj_rid_beat) ? 4'h0 : ID;
            rresp = 2'b00;
            rlast = (s_rbeat == int'(BL) - 1);
         end else begin
            rvalid = 0; rlast = 0;
         end
         awready = ($urandom_range(99) < ready_pct);
         wready  = ($urandom_range(99) < ready_pct);
         arready = ($urandom_range(99) < ready_pct);
         #1;
         f_aw = awvalid && awready; c_awaddr = awaddr;
         f_w  = wvalid && wready;   c_wdata = wdata; c_wlast = wlast;
         f_b  = bvalid && bready;
         f_ar = arvalid && arready; c_araddr = araddr;
         f_r  = rvalid && rready;
      end
   end

   // ---------------- monitor ----------------
   bit aw_stall = 0, w_stall = 0, ar_stall = 0, done_prev = 0;
   logic [31:0] aw_hold, ar_hold;
   logic [36:0] w_hold;

   initial begin : monitor
      logic [31:0] e;
      logic [32:0] ew;
      logic [15:0] er;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            aw_stall = 0; w_stall = 0; ar_stall = 0; done_prev = 0;
            continue;
         end
         if (aw_stall) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_hold});
         if (w_stall)  check("w_hold", {wvalid, wlast, wstrb, wdata}, {1'b1, w_hold});
         if (ar_stall) check("ar_hold", {arvalid, araddr}, {1'b1, ar_hold});
         aw_stall = awvalid && !awready; aw_hold = awaddr;
         w_stall  = wvalid && !wready;   w_hold = {wlast, wstrb, wdata};
         ar_stall = arvalid && !arready; ar_hold = araddr;
         if (awvalid && awready) begin
            if (aw_exp.size() == 0) check("aw_unexpected", 1, 0);
            else begin
               e = aw_exp.pop_front();
               check("aw_addr", awaddr, e);
               check("aw_attr", {awid, awlen, awburst}, {ID, 8'(BL - 1), 2'b01});
            end
         end
         if (wvalid && wready) begin
            if (w_exp.size() == 0) check("w_unexpected", 1, 0);
            else begin
               ew = w_exp.pop_front();
               check("w_beat", {wlast, wdata}, ew);
               check("w_strb", wstrb, 4'hF);
            end
         end
         if (arvalid && arready) begin
            if (ar_exp.size() == 0) check("ar_unexpected", 1, 0);
            else begin
               e = ar_exp.pop_front();
               check("ar_addr", araddr, e);
               check("ar_attr", {arid, arlen, arburst}, {ID, 8'(BL - 1), 2'b01});
            end
         end
         check("ready_excl", {bready && rready, busy === 1'b0 && (bready || rready)}, 2'b00);
         if (done && !done_prev) begin
            if (res_exp.size() == 0) check("done_unexpected", 1, 0);
            else begin
               er = res_exp.pop_front();
               check("err_count", err_count, er);
               check("pass", pass, er == 16'd0);
               check("aw_left", 64'(aw_exp.size()), 0);
               check("w_left", 64'(w_exp.size()), 0);
               check("ar_left", 64'(ar_exp.size()), 0);
            end
         end
         done_prev = done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, {busy, done, pass, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
      check({tag, "_err"}, err_count, 16'h0000);
      check({tag, "_payload"}, |{awaddr, awid, awlen, awburst, wdata, wstrb, wlast,
                                araddr, arid, arlen, arburst}, 1'b0);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
         rst_n = 1'b0;
         flush_exp();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_pass(input logic [15:0] err);
      expect_pass(err);
      pulse_start();
      check("start_accepted", {busy, done}, 2'b10);
      wait_done();
   endtask

   initial begin : stimulus
      bit seen;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Ideal slave, clean pass.
      run_pass(16'd0);
      repeat (5) @(negedge clk);
      check("done_held", {done, pass, busy}, 3'b110);

      // One flipped read data bit.
      inj_rdata_burst = 1; inj_rdata_beat = 2;
      run_pass(16'd1);
      check("fail_flags", {done, pass}, 2'b10);
      inj_rdata_burst = -1; inj_rdata_beat = -1;

      // Back-pressure on AW/W/AR.
      ready_pct = 30;
      run_pass(16'd0);
      ready_pct = 100;

      // Bad write response plus a wrong read id.
      inj_bresp_burst = 0; inj_rid_burst = 0; inj_rid_beat = 1;
      run_pass(16'd2);
      inj_bresp_burst = -1; inj_rid_burst = -1; inj_rid_beat = -1;

      // Reset while reading, then a fresh pass.
      expect_pass(16'd0);
      pulse_start();
      seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         if (rready) seen = 1;
      end
      check("reach_rd_r", seen, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midpass_reset");
      flush_exp();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_pass(16'd0);

      // Start pulse while busy must be ignored.
      expect_pass(16'd0);
      pulse_start();
      repeat (3) @(negedge clk);
      check("busy_mid", busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (20) @(negedge clk);
      check("idle_after", {busy, done, pass}, 3'b011);
      check("res_left", 64'(res_exp.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
